// File: rtl/piso_byte_tx_pkg.sv
// Shared defaults and FSM encoding for the parallel-in serial-out byte transmitter.
package piso_byte_tx_pkg;

  localparam int unsigned DefWidth   = 8;
  localparam logic        DefIdleLvl = 1'b0;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable left-shift register; the MSB is the serial output bit.
module piso_shift_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Width-1:0] data_i,
  output logic             msb_o
);

  logic [Width-1:0] sreg_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
    end else if (shift_i) begin
      sreg_q <= {sreg_q[Width-2:0], 1'b0};
    end
  end

  assign msb_o = sreg_q[Width-1];

endmodule

// File: rtl/piso_byte_tx.sv
// Byte serialiser with a one-entry hold register so consecutive frames leave the line
// without gap cycles; o_done marks when a downstream SIPO holds the complete byte.
module piso_byte_tx
  import piso_byte_tx_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter logic        IDLE_LVL = DefIdleLvl
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_SD,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned     CntW   = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             accept, last_bit, transfer;
  logic             load, shift;
  logic             msb;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    shift       = 1'b0;

    accept   = i_valid & ready_q;
    last_bit = (state_q == StShift) && (cnt_q == CntMax);
    // A held byte moves to the shifter when the line is free or the last bit is leaving.
    transfer = hold_full_q && ((state_q == StIdle) || last_bit);

    if (accept) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
    end else if (transfer) begin
      hold_full_d = 1'b0;
    end

    if (transfer) begin
      load    = 1'b1;
      cnt_d   = '0;
      state_d = StShift;
    end else if (state_q == StShift) begin
      shift = 1'b1;
      cnt_d = cnt_q + 1'b1;
      if (last_bit) begin
        state_d = StIdle;
      end
    end

    ready_d = ~hold_full_d;
    done_d  = last_bit;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  piso_shift_reg #(
    .Width (WIDTH)
  ) u_shift_reg (
    .clk_i   (i_clk),
    .rst_ni  (i_rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (hold_q),
    .msb_o   (msb)
  );

  assign o_SD    = (state_q == StShift) ? msb : IDLE_LVL;
  assign o_busy  = (state_q == StShift);
  assign o_ready = ready_q;
  assign o_done  = done_q;

endmodule
